// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle for word_serializer.
// The upstream/test side uses master; the serializer uses slave.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;
    logic             stall;
    logic             serialOut;
    logic             serialValid;
    logic             busy;
    logic             frameDone;

    modport master (
        output dataIn,
        output dataValid,
        output stall,
        input  dataReady,
        input  serialOut,
        input  serialValid,
        input  busy,
        input  frameDone
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        input  stall,
        output dataReady,
        output serialOut,
        output serialValid,
        output busy,
        output frameDone
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-in, serial-out stage feeding the pattern detector's serial input.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
module word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    word_serializer_if.slave bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] bitCnt, cntNext;
    logic [WIDTH-1:0] shiftReg, shiftNext, rotated;
    logic             outReg, outNext;
    logic             validReg, validNext;
    logic             busyReg, busyNext;
    logic             doneReg, doneNext;
    logic             firstBit, nextBit, advBit;
    logic             lastBit, accept;
`ifdef SERIALIZER_PARITY_EN
    logic             parityReg, parityNext;
`endif

    // The register rotates so the bit to present next always sits at a fixed position.
    if (MSB_FIRST) begin : g_msb
        assign firstBit = bus.dataIn[WIDTH-1];
        assign rotated  = {shiftReg[WIDTH-2:0], shiftReg[WIDTH-1]};
        assign nextBit  = shiftReg[WIDTH-2];
    end else begin : g_lsb
        assign firstBit = bus.dataIn[0];
        assign rotated  = {shiftReg[0], shiftReg[WIDTH-1:1]};
        assign nextBit  = shiftReg[1];
    end

`ifdef SERIALIZER_PARITY_EN
    assign advBit = (bitCnt == CNT_W'(WIDTH - 1)) ? parityReg : nextBit;
`else
    assign advBit = nextBit;
`endif

    assign lastBit       = (state == SHIFT) && (bitCnt == CNT_W'(FRAME - 1));
    assign bus.dataReady = !reset && !bus.stall && ((state == IDLE) || lastBit);
    assign accept        = bus.dataValid && bus.dataReady;

    assign bus.serialOut   = outReg;
    assign bus.serialValid = validReg;
    assign bus.busy        = busyReg;
    assign bus.frameDone   = doneReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            outReg    <= 1'b0;
            validReg  <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            bitCnt    <= cntNext;
            shiftReg  <= shiftNext;
            outReg    <= outNext;
            validReg  <= validNext;
            busyReg   <= busyNext;
            doneReg   <= doneNext;
`ifdef SERIALIZER_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

    // A stalled SHIFT cycle falls through to the defaults: everything holds, valid/done drop.
    always_comb begin
        stateNext  = state;
        cntNext    = bitCnt;
        shiftNext  = shiftReg;
        outNext    = outReg;
        validNext  = 1'b0;
        busyNext   = busyReg;
        doneNext   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parityNext = parityReg;
`endif
        if (accept) begin
            stateNext  = SHIFT;
            cntNext    = '0;
            shiftNext  = bus.dataIn;
            outNext    = firstBit;
            validNext  = 1'b1;
            busyNext   = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parityNext = ^bus.dataIn;
`endif
        end else if (state == SHIFT && !bus.stall) begin
            if (lastBit) begin
                stateNext = IDLE;
                cntNext   = '0;
                outNext   = 1'b0;
                busyNext  = 1'b0;
            end else begin
                cntNext   = bitCnt + CNT_W'(1);
                shiftNext = rotated;
                outNext   = advBit;
                validNext = 1'b1;
                doneNext  = (bitCnt == CNT_W'(FRAME - 2));
            end
        end else if (state == IDLE) begin
            outNext  = 1'b0;
            busyNext = 1'b0;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: MSB-first and LSB-first instances share one stimulus stream.
// Honours SERIALIZER_PARITY_EN to match the frame length of the design under test.
module tb_word_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } expBit_t;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [WIDTH-1:0] dataIn    = '0;
    logic             dataValid = 1'b0;
    logic             stall     = 1'b0;

    expBit_t expQ[2][$];
    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;
    int      accCyc = 0;
    int      doneCyc[2];
    int      runLen[2];
    int      maxRun[2];
    logic    prevOut[2];
    logic    prevBusy[2];
    logic    prevStall = 1'b0;
    logic    prevReset = 1'b1;
    logic    accPrev   = 1'b0;
    logic    monOn     = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    word_serializer_if #(.WIDTH(WIDTH)) busM ();
    word_serializer_if #(.WIDTH(WIDTH)) busL ();

    assign busM.dataIn    = dataIn;
    assign busM.dataValid = dataValid;
    assign busM.stall     = stall;
    assign busL.dataIn    = dataIn;
    assign busL.dataValid = dataValid;
    assign busL.stall     = stall;

    word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
        .clk   (clk),
        .reset (reset),
        .bus   (busM)
    );

    word_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
        .clk   (clk),
        .reset (reset),
        .bus   (busL)
    );

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame: word bits in transmit order, then the parity bit when enabled.
    task automatic pushFrame(input logic [WIDTH-1:0] d);
        expBit_t e;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < FRAME; i++) begin
                if (i == WIDTH) e.b = ^d;
                else            e.b = (k == 0) ? d[WIDTH-1-i] : d[i];
                e.last = (i == FRAME - 1);
                expQ[k].push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic s,
                                 input logic r, output logic acc);
        @(posedge clk);
        #1;
        if (reset) begin
            expQ[0].delete();
            expQ[1].delete();
            compare("resetStateMsb", {busM.serialOut, busM.serialValid, busM.busy, busM.frameDone}, 0);
            compare("resetStateLsb", {busL.serialOut, busL.serialValid, busL.busy, busL.frameDone}, 0);
        end
        if (accPrev)
            compare("firstBitLatency", {busM.serialValid, busL.serialValid}, 2'b11);
        dataValid = v;
        dataIn    = d;
        stall     = s;
        reset     = r;
        #2;
        if (r || s)
            compare("readyBlocked", busM.dataReady, 0);
        acc = v && busM.dataReady;
        if (acc) begin
            pushFrame(d);
            accCyc = cyc;
        end
        accPrev = acc;
    endtask

    task automatic checkOutput(input int k, input logic so, input logic sv, input logic bz, input logic fd);
        expBit_t e;
        if (prevStall && prevBusy[k] && !prevReset)
            compare("stallHold", {sv, so}, {1'b0, prevOut[k]});
        if (sv) begin
            if (expQ[k].size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedBit: dut %0d got serialValid=1 expected no pending bits", k);
            end else begin
                e = expQ[k].pop_front();
                compare("serialBit", so, e.b);
                compare("frameDone", fd, e.last);
                compare("busyWithValid", bz, 1);
            end
            runLen[k]++;
            if (runLen[k] > maxRun[k]) maxRun[k] = runLen[k];
            if (fd) doneCyc[k] = cyc;
        end else begin
            runLen[k] = 0;
            compare("doneWithoutValid", fd, 0);
        end
        prevOut[k]  = so;
        prevBusy[k] = bz;
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            checkOutput(0, busM.serialOut, busM.serialValid, busM.busy, busM.frameDone);
            checkOutput(1, busL.serialOut, busL.serialValid, busL.busy, busL.frameDone);
        end
        prevStall = stall;
        prevReset = reset;
    end

    initial begin
        logic acc;
        int   t0;
        int   n;
        int   accAt[2];

        for (int k = 0; k < 2; k++) begin
            doneCyc[k]  = 0;
            runLen[k]   = 0;
            maxRun[k]   = 0;
            prevOut[k]  = 1'b0;
            prevBusy[k] = 1'b0;
        end

        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, acc);
        compare("readyInReset", acc, 0);
        monOn = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);

        // Single word, idle afterwards.
        applyStimulus(1'b1, 8'hB5, 1'b0, 1'b0, acc);
        compare("acceptIdle", acc, 1);
        t0 = accCyc;
        repeat (FRAME + 3) applyStimulus(1'b0, WIDTH'($urandom), 1'b0, 1'b0, acc);
        compare("doneLatencyMsb", doneCyc[0] - t0, FRAME);
        compare("doneLatencyLsb", doneCyc[1] - t0, FRAME);
        compare("idleAfterFrame", {busM.busy, busL.busy}, 0);

        // Back-to-back words with dataValid held high.
        maxRun[0] = 0;
        maxRun[1] = 0;
        n = 0;
        accAt[0] = 0;
        accAt[1] = 0;
        for (int i = 0; i < 3 * FRAME && n < 2; i++) begin
            applyStimulus(1'b1, (n == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0, acc);
            if (acc) begin
                accAt[n] = i;
                n++;
            end
        end
        compare("b2bAccepts", n, 2);
        compare("b2bGap", accAt[1] - accAt[0], FRAME);
        repeat (FRAME + 3) applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        compare("b2bRunMsb", maxRun[0], 2 * FRAME);
        compare("b2bRunLsb", maxRun[1], 2 * FRAME);

        // Three stall cycles after the third bit.
        applyStimulus(1'b1, 8'hB5, 1'b0, 1'b0, acc);
        t0 = accCyc;
        for (int i = 1; i <= FRAME + 6; i++)
            applyStimulus(1'b0, WIDTH'($urandom), (i >= 3 && i <= 5), 1'b0, acc);
        compare("stallDoneMsb", doneCyc[0] - t0, FRAME + 3);
        compare("stallDoneLsb", doneCyc[1] - t0, FRAME + 3);

        // Reset after the fourth bit, then a clean frame.
        applyStimulus(1'b1, 8'hB5, 1'b0, 1'b0, acc);
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, '0, 1'b0, (i == 4), acc);
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, acc);
        compare("acceptAfterReset", acc, 1);
        t0 = accCyc;
        repeat (FRAME + 3) applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        compare("postResetDone", doneCyc[0] - t0, FRAME);

        // Random traffic with stalls and occasional resets.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0, acc);
        repeat (3 * FRAME) applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        compare("drainMsb", expQ[0].size(), 0);
        compare("drainLsb", expQ[1].size(), 0);
        compare("finalIdle", {busM.busy, busL.busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
